// File: rtl/instr_mem_fetch.sv
// +--------------------------------------------------------------------------+
// | instr_mem_fetch: instruction memory with a registered valid/ready fetch  |
// | port, range/alignment error flags, program-load port and fetch counter.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module instr_mem_fetch #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 64,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_instr,
  output logic [XLEN-1:0] rsp_addr,
  output logic [1:0]      rsp_err,
  input  logic            prog_we,
  input  logic [XLEN-1:0] prog_addr,
  input  logic [XLEN-1:0] prog_data,
  output logic [31:0]     fetch_cnt
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [XLEN-1:0] DEPTH_X = XLEN'(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];

  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_instr_q, rsp_instr_d;
  logic [XLEN-1:0] rsp_addr_q,  rsp_addr_d;
  logic [1:0]      rsp_err_q,   rsp_err_d;
  logic [31:0]     fetch_cnt_q, fetch_cnt_d;

  logic            w_misaligned;
  logic            w_out_of_range;
  logic            w_accept;
  logic [XLEN-1:0] w_rd_word;
  logic            w_prog_ok;

  assign req_ready = !reset && !flush && (!rsp_valid_q || rsp_ready);

  always_comb begin
    w_misaligned   = (req_addr[1:0] != 2'b00);
    w_out_of_range = ((req_addr >> 2) >= DEPTH_X);
    w_accept       = req_valid && req_ready;
    w_rd_word      = mem_q[req_addr[AW+1:2]];
    w_prog_ok      = prog_we && (prog_addr < DEPTH_X);
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;
    fetch_cnt_d = fetch_cnt_q;
    if (w_accept) begin
      rsp_valid_d = 1'b1;
      rsp_addr_d  = req_addr;
      rsp_err_d   = {w_out_of_range, w_misaligned};
      rsp_instr_d = (w_misaligned || w_out_of_range) ? NOP_INSTR : w_rd_word;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end else if (flush || rsp_ready) begin
      // Data fields are left untouched; only the valid flag drops.
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= 2'b00;
      fetch_cnt_q <= 32'd0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // No reset on the array; a same-edge fetch sees the old word (read-before-write).
  always_ff @(posedge clk) begin
    if (!reset && w_prog_ok) begin
      mem_q[prog_addr[AW-1:0]] <= prog_data;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_err   = rsp_err_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_fetch.sv
// +--------------------------------------------------------------------------+
// | tb_instr_mem_fetch: directed scenarios plus randomized traffic checked   |
// | every cycle against a behavioural model of the fetch memory.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_instr_mem_fetch;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_err;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic [31:0] fetch_cnt;

  instr_mem_fetch #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a word array plus the expected response slot.
  logic [31:0] model_mem [DEPTH];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_addr;
  logic [1:0]  m_err;
  logic [31:0] m_cnt;

  function automatic logic model_ready();
    return !reset && !flush && (!m_valid || rsp_ready);
  endfunction

  function automatic logic [31:0] model_fetch(input logic [31:0] a);
    if ((a % 4) != 0 || (a / 4) >= DEPTH) return NOP;
    return model_mem[int'(a / 4)];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_instr <= 32'd0;
      m_addr  <= 32'd0;
      m_err   <= 2'b00;
      m_cnt   <= 32'd0;
    end else begin
      if (req_valid && model_ready()) begin
        m_valid <= 1'b1;
        m_addr  <= req_addr;
        m_err   <= {(req_addr / 4) >= DEPTH, (req_addr % 4) != 0};
        m_instr <= model_fetch(req_addr);
        m_cnt   <= m_cnt + 32'd1;
      end else if (flush || rsp_ready) begin
        m_valid <= 1'b0;
      end
      if (prog_we && prog_addr < DEPTH) model_mem[int'(prog_addr)] <= prog_data;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("req_ready", 64'(req_ready), 64'(model_ready()));
      check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      check("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
      if (m_valid) begin
        check("rsp_instr", 64'(rsp_instr), 64'(m_instr));
        check("rsp_addr",  64'(rsp_addr),  64'(m_addr));
        check("rsp_err",   64'(rsp_err),   64'(m_err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    rsp_ready = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    step();
    checking = 1'b1;
    step();
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_fetch_cnt", 64'(fetch_cnt), 64'd0);
    check("reset_rsp_instr", 64'(rsp_instr), 64'd0);
    reset = 1'b0;

    // Program load: words 0..5 hold recognisable values, the rest random.
    for (int i = 0; i < DEPTH; i++) begin
      prog_we = 1'b1; prog_addr = i;
      prog_data = (i < 6) ? (32'h10000000 + i) : $urandom;
      step();
    end
    prog_we = 1'b0;

    // T1 back-to-back fetches
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = i * 4;
      step();
      check("t1_valid", 64'(rsp_valid), 64'd1);
      check("t1_instr", 64'(rsp_instr), 64'(32'h10000000 + i));
      check("t1_addr",  64'(rsp_addr),  64'(i * 4));
    end
    check("t1_cnt", 64'(fetch_cnt), 64'd4);
    req_valid = 1'b0;
    step();
    check("t1_drain", 64'(rsp_valid), 64'd0);

    // T2 stall
    req_valid = 1'b1; req_addr = 32'h4;
    step();
    rsp_ready = 1'b0; req_addr = 32'h8;
    #1;
    check("t2_ready_low", 64'(req_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold_instr", 64'(rsp_instr), 64'h10000001);
      check("t2_hold_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("t2_ready_high", 64'(req_ready), 64'd1);
    step();
    check("t2_word2", 64'(rsp_instr), 64'h10000002);
    check("t2_cnt", 64'(fetch_cnt), 64'd6);

    // T3 flush
    req_addr = 32'h10;
    step();
    check("t3_word4", 64'(rsp_instr), 64'h10000004);
    flush = 1'b1; req_addr = 32'h14;
    #1;
    check("t3_ready", 64'(req_ready), 64'd0);
    step();
    check("t3_valid", 64'(rsp_valid), 64'd0);
    check("t3_cnt", 64'(fetch_cnt), 64'd7);
    flush = 1'b0;

    // T4 errors
    req_addr = 32'h6;
    step();
    check("t4_mis_instr", 64'(rsp_instr), 64'(NOP));
    check("t4_mis_err", 64'(rsp_err), 64'd1);
    req_addr = DEPTH * 4;
    step();
    check("t4_oor_instr", 64'(rsp_instr), 64'(NOP));
    check("t4_oor_err", 64'(rsp_err), 64'd2);
    req_addr = DEPTH * 4 + 2;
    step();
    check("t4_both_err", 64'(rsp_err), 64'd3);
    check("t4_cnt", 64'(fetch_cnt), 64'd10);

    // T5 collision and ignored out-of-range write
    prog_we = 1'b1; prog_addr = 5; prog_data = 32'hBBBBBBBB; req_addr = 32'h14;
    step();
    check("t5_old_word", 64'(rsp_instr), 64'h10000005);
    prog_addr = DEPTH; prog_data = 32'hDEADBEEF;
    step();
    check("t5_new_word", 64'(rsp_instr), 64'hBBBBBBBB);
    prog_we = 1'b0; req_addr = 32'h0;
    step();
    check("t5_word0_kept", 64'(rsp_instr), 64'h10000000);
    req_valid = 1'b0;
    step();

    // T6 reset during a stall
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'hC;
    step();
    req_valid = 1'b0;
    step();
    check("t6_stalled", 64'(rsp_valid), 64'd1);
    reset = 1'b1;
    step();
    check("t6_valid", 64'(rsp_valid), 64'd0);
    check("t6_cnt", 64'(fetch_cnt), 64'd0);
    reset = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'hC;
    step();
    check("t6_mem_kept", 64'(rsp_instr), 64'h10000003);
    check("t6_cnt_after", 64'(fetch_cnt), 64'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int kind;
      kind      = $urandom_range(0, 9);
      req_valid = ($urandom_range(0, 3) != 0);
      if (kind <= 6)      req_addr = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (kind == 7) req_addr = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
      else if (kind == 8) req_addr = $urandom;
      else                req_addr = DEPTH * 4 - 4 + $urandom_range(0, 7);
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      prog_we   = ($urandom_range(0, 3) == 0);
      prog_addr = ($urandom_range(0, 7) == 0) ? DEPTH + $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
      prog_data = $urandom;
      step();
    end

    reset = 1'b0; req_valid = 1'b0; flush = 1'b0; prog_we = 1'b0;
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
